// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pkg
//  Purpose  : Shared widths and referee state encoding for the pong referee
//             block and its ball-controller interface.
//  Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int COORD_W = 10;  // pixel coordinate width
    localparam int SCORE_W = 4;   // per-player score width
    localparam int VEL_W   = 4;   // ball x velocity width
    localparam int SIZE_W  = 5;   // ball width/height field width

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        SERVE      = 3'd2,
        ARM        = 3'd3,
        PLAY       = 3'd4,
        WAIT_FLIP  = 3'd5,
        GAME_OVER  = 3'd6
    } pong_state_t;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/pong_referee_if.sv
`default_nettype none
// ============================================================================
//  Module   : pong_referee_if
//  Purpose  : Link between the ball collision controller (master) and the
//             referee (slave).
//  Signals  : x_ball/y_ball/x_ball_dir/width_ball/height_ball  ball -> referee
//             bounce_x/serve/serve_dir/ball_active/ball_vel     referee -> ball
//  Revision : 1.0 - initial release
// ============================================================================
interface pong_referee_if;
    import pong_pkg::*;

    logic [COORD_W-1:0] x_ball;
    logic [COORD_W-1:0] y_ball;
    logic               x_ball_dir;
    logic [SIZE_W-1:0]  width_ball;
    logic [SIZE_W-1:0]  height_ball;
    logic               bounce_x;
    logic               serve;
    logic               serve_dir;
    logic               ball_active;
    logic [VEL_W-1:0]   ball_vel;

    modport master (
        output x_ball, y_ball, x_ball_dir, width_ball, height_ball,
        input  bounce_x, serve, serve_dir, ball_active, ball_vel
    );

    modport slave (
        input  x_ball, y_ball, x_ball_dir, width_ball, height_ball,
        output bounce_x, serve, serve_dir, ball_active, ball_vel
    );

endinterface : pong_referee_if
`default_nettype wire

// File: rtl/paddle_hit_detect.sv
`default_nettype none
// ============================================================================
//  Module   : paddle_hit_detect
//  Purpose  : Combinational ball/paddle overlap test for one side.
//             SIDE=0: left paddle, tested on the ball left edge while moving left.
//             SIDE=1: right paddle, tested on the ball right edge while moving right.
//  Ports    : i_x_ball, i_y_ball, i_x_ball_dir, i_width_ball, i_height_ball,
//             i_y_paddle (paddle top edge), o_hit
//  Revision : 1.0 - initial release
// ============================================================================
module paddle_hit_detect
    import pong_pkg::*;
#(
    parameter bit SIDE     = 1'b0,
    parameter int X_FACE   = 40,
    parameter int PADDLE_W = 8,
    parameter int PADDLE_H = 64
) (
    input  wire logic [COORD_W-1:0] i_x_ball,
    input  wire logic [COORD_W-1:0] i_y_ball,
    input  wire logic               i_x_ball_dir,
    input  wire logic [SIZE_W-1:0]  i_width_ball,
    input  wire logic [SIZE_W-1:0]  i_height_ball,
    input  wire logic [COORD_W-1:0] i_y_paddle,
    output logic                    o_hit
);

    // One extra bit so position + size never wraps.
    localparam int                  c_EXT_W    = COORD_W + 1;
    localparam logic [c_EXT_W-1:0]  c_X_FACE   = c_EXT_W'(X_FACE);
    localparam logic [c_EXT_W-1:0]  c_PADDLE_W = c_EXT_W'(PADDLE_W);
    localparam logic [c_EXT_W-1:0]  c_PADDLE_H = c_EXT_W'(PADDLE_H);

    logic [c_EXT_W-1:0] w_x_left;
    logic [c_EXT_W-1:0] w_x_right;
    logic [c_EXT_W-1:0] w_edge;
    logic [c_EXT_W-1:0] w_y_top;
    logic [c_EXT_W-1:0] w_y_bot;
    logic [c_EXT_W-1:0] w_pad_top;
    logic [c_EXT_W-1:0] w_pad_bot;
    logic               w_dir_ok;
    logic               w_y_ok;
    logic               w_x_ok;

    assign w_x_left  = {1'b0, i_x_ball};
    assign w_x_right = w_x_left + {{(c_EXT_W-SIZE_W){1'b0}}, i_width_ball};
    assign w_y_top   = {1'b0, i_y_ball};
    assign w_y_bot   = w_y_top + {{(c_EXT_W-SIZE_W){1'b0}}, i_height_ball};
    assign w_pad_top = {1'b0, i_y_paddle};
    assign w_pad_bot = w_pad_top + c_PADDLE_H;

    // The edge facing the paddle: left edge for the left side, right edge otherwise.
    assign w_edge   = SIDE ? w_x_right : w_x_left;
    assign w_dir_ok = (i_x_ball_dir == SIDE);
    assign w_y_ok   = (w_y_bot >= w_pad_top) && (w_y_top <= w_pad_bot);

    generate
        if (SIDE == 1'b0) begin : g_left
            // Leading edge inside (X_FACE-PADDLE_W, X_FACE]
            assign w_x_ok = (w_edge <= c_X_FACE) && ((w_edge + c_PADDLE_W) > c_X_FACE);
        end else begin : g_right
            // Leading edge inside [X_FACE, X_FACE+PADDLE_W)
            assign w_x_ok = (w_edge >= c_X_FACE) && (w_edge < (c_X_FACE + c_PADDLE_W));
        end
    endgenerate

    assign o_hit = w_dir_ok && w_x_ok && w_y_ok;

endmodule : paddle_hit_detect
`default_nettype wire

// File: rtl/pong_referee.sv
`default_nettype none
// ============================================================================
//  Module   : pong_referee
//  Purpose  : Pong referee. Watches the ball every game tick, requests paddle
//             bounces, scores goals, re-serves after a delay and detects the
//             end of the match.
//  Ports    : game_clk, reset (sync, active high), start,
//             y_lpaddle, y_rpaddle, ball (pong_referee_if.slave),
//             score_l, score_r, game_over, winner
//  Config   : SPEEDUP_EN - when defined, every HITS_PER_UP-th paddle hit raises
//             ball_vel by one (saturating at VEL_MAX); reset to VEL_INIT on serve.
//  Revision : 1.0 - initial release
// ============================================================================
module pong_referee
    import pong_pkg::*;
#(
    parameter int X_LPADDLE   = 40,
    parameter int X_RPADDLE   = 600,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int X_LGOAL     = 8,
    parameter int X_RGOAL     = 632,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 120,
    parameter int VEL_INIT    = 2,
    parameter int VEL_MAX     = 6,
    parameter int HITS_PER_UP = 4
) (
    input  wire logic               game_clk,
    input  wire logic               reset,
    input  wire logic               start,
    input  wire logic [COORD_W-1:0] y_lpaddle,
    input  wire logic [COORD_W-1:0] y_rpaddle,
    pong_referee_if.slave           ball,
    output logic [SCORE_W-1:0]      score_l,
    output logic [SCORE_W-1:0]      score_r,
    output logic                    game_over,
    output logic                    winner
);

    localparam int                  c_EXT_W      = COORD_W + 1;
    localparam int                  c_CNT_W      = $clog2(SERVE_TICKS + 1);
    localparam logic [c_CNT_W-1:0]  c_SERVE_LAST = c_CNT_W'(SERVE_TICKS - 1);
    localparam logic [SCORE_W-1:0]  c_WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [c_EXT_W-1:0]  c_X_LGOAL    = c_EXT_W'(X_LGOAL);
    localparam logic [c_EXT_W-1:0]  c_X_RGOAL    = c_EXT_W'(X_RGOAL);
    // Serve speed never starts above the ceiling.
    localparam logic [VEL_W-1:0]    c_VEL_INIT   = VEL_W'((VEL_INIT > VEL_MAX) ? VEL_MAX : VEL_INIT);

    pong_state_t         r_state,     w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic [SCORE_W-1:0]  r_score_l,   w_score_l_nxt;
    logic [SCORE_W-1:0]  r_score_r,   w_score_r_nxt;
    logic                r_bounce,    w_bounce_nxt;
    logic                r_serve,     w_serve_nxt;
    logic                r_serve_dir, w_serve_dir_nxt;
    logic                r_active,    w_active_nxt;
    logic [VEL_W-1:0]    r_vel,       w_vel_nxt;
    logic                r_game_over, w_game_over_nxt;
    logic                r_winner,    w_winner_nxt;
    logic                r_flip_dir,  w_flip_dir_nxt;

`ifdef SPEEDUP_EN
    localparam int                  c_HITS_W    = $clog2(HITS_PER_UP + 1);
    localparam logic [c_HITS_W-1:0] c_HITS_LAST = c_HITS_W'(HITS_PER_UP - 1);
    localparam logic [VEL_W-1:0]    c_VEL_MAX   = VEL_W'(VEL_MAX);
    logic [c_HITS_W-1:0] r_hits, w_hits_nxt;
`else
    // Speed-up disabled: HITS_PER_UP has no effect on this build.
    if (HITS_PER_UP < 1) begin : g_no_speedup
    end
`endif

    logic               w_hit_l;
    logic               w_hit_r;
    logic               w_goal_l;
    logic               w_goal_r;
    logic [c_EXT_W-1:0] w_x_right;
    logic [SCORE_W-1:0] w_score_l_inc;
    logic [SCORE_W-1:0] w_score_r_inc;

    paddle_hit_detect #(
        .SIDE(1'b0), .X_FACE(X_LPADDLE), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)
    ) u_hit_l (
        .i_x_ball(ball.x_ball), .i_y_ball(ball.y_ball), .i_x_ball_dir(ball.x_ball_dir),
        .i_width_ball(ball.width_ball), .i_height_ball(ball.height_ball),
        .i_y_paddle(y_lpaddle), .o_hit(w_hit_l)
    );

    paddle_hit_detect #(
        .SIDE(1'b1), .X_FACE(X_RPADDLE), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)
    ) u_hit_r (
        .i_x_ball(ball.x_ball), .i_y_ball(ball.y_ball), .i_x_ball_dir(ball.x_ball_dir),
        .i_width_ball(ball.width_ball), .i_height_ball(ball.height_ball),
        .i_y_paddle(y_rpaddle), .o_hit(w_hit_r)
    );

    assign w_x_right     = {1'b0, ball.x_ball} + {{(c_EXT_W-SIZE_W){1'b0}}, ball.width_ball};
    assign w_goal_l      = !ball.x_ball_dir && ({1'b0, ball.x_ball} <= c_X_LGOAL);
    assign w_goal_r      = ball.x_ball_dir && (w_x_right >= c_X_RGOAL);
    assign w_score_l_inc = r_score_l + SCORE_W'(1);
    assign w_score_r_inc = r_score_r + SCORE_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_score_l_nxt   = r_score_l;
        w_score_r_nxt   = r_score_r;
        w_bounce_nxt    = 1'b0;
        w_serve_dir_nxt = r_serve_dir;
        w_vel_nxt       = r_vel;
        w_winner_nxt    = r_winner;
        w_flip_dir_nxt  = r_flip_dir;
`ifdef SPEEDUP_EN
        w_hits_nxt      = r_hits;
`endif
        case (r_state)
            IDLE, GAME_OVER: begin
                if (start) begin
                    w_state_nxt     = SERVE_WAIT;
                    w_cnt_nxt       = '0;
                    w_score_l_nxt   = '0;
                    w_score_r_nxt   = '0;
                    w_serve_dir_nxt = 1'b1;
                    w_winner_nxt    = 1'b0;
                end
            end
            SERVE_WAIT: begin
                if (r_cnt == c_SERVE_LAST) begin
                    w_state_nxt = SERVE;
                    w_vel_nxt   = c_VEL_INIT;
`ifdef SPEEDUP_EN
                    w_hits_nxt  = '0;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            SERVE:   w_state_nxt = ARM;
            ARM:     w_state_nxt = PLAY;
            PLAY: begin
                // Hit takes priority over goal if both ever evaluate true.
                if (w_hit_l || w_hit_r) begin
                    w_state_nxt    = WAIT_FLIP;
                    w_bounce_nxt   = 1'b1;
                    w_flip_dir_nxt = ball.x_ball_dir;
`ifdef SPEEDUP_EN
                    if (r_hits == c_HITS_LAST) begin
                        w_hits_nxt = '0;
                        if (r_vel < c_VEL_MAX) begin
                            w_vel_nxt = r_vel + VEL_W'(1);
                        end
                    end else begin
                        w_hits_nxt = r_hits + c_HITS_W'(1);
                    end
`endif
                end else if (w_goal_l) begin
                    w_score_r_nxt = w_score_r_inc;
                    if (w_score_r_inc == c_WIN) begin
                        w_state_nxt  = GAME_OVER;
                        w_winner_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = SERVE_WAIT;
                        w_cnt_nxt       = '0;
                        w_serve_dir_nxt = 1'b0;
                    end
                end else if (w_goal_r) begin
                    w_score_l_nxt = w_score_l_inc;
                    if (w_score_l_inc == c_WIN) begin
                        w_state_nxt  = GAME_OVER;
                        w_winner_nxt = 1'b0;
                    end else begin
                        w_state_nxt     = SERVE_WAIT;
                        w_cnt_nxt       = '0;
                        w_serve_dir_nxt = 1'b1;
                    end
                end
            end
            WAIT_FLIP: begin
                // Detection resumes only once the ball controller has flipped direction.
                if (ball.x_ball_dir != r_flip_dir) begin
                    w_state_nxt = PLAY;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Level outputs follow the state being entered so they are registered.
        w_serve_nxt     = (w_state_nxt == SERVE);
        w_active_nxt    = (w_state_nxt == PLAY) || (w_state_nxt == WAIT_FLIP);
        w_game_over_nxt = (w_state_nxt == GAME_OVER);
    end

    always_ff @(posedge game_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_bounce    <= 1'b0;
            r_serve     <= 1'b0;
            r_serve_dir <= 1'b1;
            r_active    <= 1'b0;
            r_vel       <= c_VEL_INIT;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
            r_flip_dir  <= 1'b0;
`ifdef SPEEDUP_EN
            r_hits      <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_score_l   <= w_score_l_nxt;
            r_score_r   <= w_score_r_nxt;
            r_bounce    <= w_bounce_nxt;
            r_serve     <= w_serve_nxt;
            r_serve_dir <= w_serve_dir_nxt;
            r_active    <= w_active_nxt;
            r_vel       <= w_vel_nxt;
            r_game_over <= w_game_over_nxt;
            r_winner    <= w_winner_nxt;
            r_flip_dir  <= w_flip_dir_nxt;
`ifdef SPEEDUP_EN
            r_hits      <= w_hits_nxt;
`endif
        end
    end

    assign ball.bounce_x    = r_bounce;
    assign ball.serve       = r_serve;
    assign ball.serve_dir   = r_serve_dir;
    assign ball.ball_active = r_active;
    assign ball.ball_vel    = r_vel;
    assign score_l          = r_score_l;
    assign score_r          = r_score_r;
    assign game_over        = r_game_over;
    assign winner           = r_winner;

endmodule : pong_referee
`default_nettype wire
